uart_rx_stop_checker: RTL and testbench

//  Parametrised UART receive stop-bit checker. It validates 1..MAX_STOP stop bits per frame at a

---
 rtl/uart_rx_stop_checker.sv | 210 +++++++++++++++++++++
 tb/tb_uart_rx_stop_checker.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_stop_checker.sv
// -----------------------------------------------------------------------------
// uart_rx_stop_checker
//   UART receive stop-bit checker. During the stop phase announced by the Rx
//   FSM it samples each of 1..MAX_STOP stop bits at a programmable point
//   inside the bit. It then emits a one-cycle frame-done pulse together with
//   the stop-error status, and keeps a saturating count of bad frames.
//
//   Optional feature macro: UART_RX_BREAK_DET_EN
//     When defined, adds the Frame_All_Zero input and the Brk_Det output.
//     Brk_Det reports a break condition: all data/parity bits were 0 and
//     every stop sample was 0.
// -----------------------------------------------------------------------------
module uart_rx_stop_checker #(
  parameter int PRESCALE_W    = 8,
  parameter int MAX_STOP      = 2,
  parameter int SAMPLE_OFFSET = 2,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Stp_Chk_En,
  input  logic                  Sampled_Bit,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic [PRESCALE_W-1:0] Edge_Cnt,
  input  logic [1:0]            Stop_Bits,
  input  logic                  Err_Cnt_Clr,
`ifdef UART_RX_BREAK_DET_EN
  input  logic                  Frame_All_Zero,
  output logic                  Brk_Det,
`endif
  output logic                  Stp_Busy,
  output logic                  Stp_Done,
  output logic                  Stp_Err,
  output logic [ERR_CNT_W-1:0]  Err_Cnt
);

  // One extra bit so (Prescale>>1)+SAMPLE_OFFSET cannot wrap before the clamp.
  localparam int SPW = PRESCALE_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STOP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     idx_q, idx_d;      // stop bit currently being checked
  logic [1:0]     n_q, n_d;          // stop bits latched for this frame
  logic           err_q, err_d;      // any stop sample seen as 0 so far
  logic           rearm_q;           // blocks retrigger until Stp_Chk_En drops
  logic           load_status;       // last EP reached: capture frame result

  logic [SPW-1:0] prescale_ext;
  logic [SPW-1:0] edge_ext;
  logic [SPW-1:0] sp_raw;
  logic [SPW-1:0] sp_pt;
  logic [SPW-1:0] ep_pt;
  logic           at_sp;
  logic           at_ep;
  logic           err_fold;
  logic [1:0]     stop_n;

`ifdef UART_RX_BREAK_DET_EN
  logic           zero_q, zero_d;    // every stop sample so far was 0
  logic           zero_fold;
`endif

  // Sample and end points within the current stop bit.
  assign prescale_ext = {1'b0, Prescale};
  assign edge_ext     = {1'b0, Edge_Cnt};
  assign sp_raw       = (prescale_ext >> 1) + SPW'(SAMPLE_OFFSET);
  assign ep_pt        = prescale_ext - SPW'(1);
  assign sp_pt        = (sp_raw > ep_pt) ? ep_pt : sp_raw;
  assign at_sp        = (edge_ext == sp_pt);
  assign at_ep        = (edge_ext == ep_pt);

  // The current sample is folded in combinationally. When SP==EP, the last
  // sample still reaches the status captured on the same edge.
  assign err_fold     = err_q | (at_sp & ~Sampled_Bit);
`ifdef UART_RX_BREAK_DET_EN
  assign zero_fold    = zero_q & ~(at_sp & Sampled_Bit);
`endif

  // Normalise the requested stop-bit count: 0 means 1; clamp to MAX_STOP.
  always_comb begin
    stop_n = Stop_Bits;
    if (Stop_Bits == 2'd0) begin
      stop_n = 2'd1;
    end else if (int'(Stop_Bits) > MAX_STOP) begin
      stop_n = 2'(MAX_STOP);
    end
  end

  // Moore-style status outputs decoded from the state register.
  assign Stp_Busy = (state_q == STOP);
  assign Stp_Done = (state_q == DONE);

  // State and frame-context registers.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and the processes stay order-independent.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      n_q     <= 2'd1;
      err_q   <= 1'b0;
      rearm_q <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      zero_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      err_q   <= err_d;
`ifdef UART_RX_BREAK_DET_EN
      zero_q  <= zero_d;
`endif
      if (state_q == DONE) begin
        rearm_q <= 1'b1;
      end else if (!Stp_Chk_En) begin
        rearm_q <= 1'b0;
      end
    end
  end

  // Next-state logic: enter on stop phase, step through stop bits, abort on drop.
  // NOTE: every signal written here gets a default first; otherwise any
  // path that skips an assignment would infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    n_d         = n_q;
    err_d       = err_q;
    load_status = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    zero_d      = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (Stp_Chk_En && !rearm_q) begin
          state_d = STOP;
          idx_d   = 2'd0;
          n_d     = stop_n;
          err_d   = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
          zero_d  = 1'b1;
`endif
        end
      end
      STOP: begin
        if (!Stp_Chk_En) begin
          // Aborted frame: drop back silently, status outputs untouched.
          state_d = IDLE;
        end else begin
          err_d = err_fold;
`ifdef UART_RX_BREAK_DET_EN
          zero_d = zero_fold;
`endif
          if (at_ep) begin
            if (idx_q == n_q - 2'd1) begin
              state_d     = DONE;
              load_status = 1'b1;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Frame status: captured on the edge into DONE so it is valid with Stp_Done.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      Stp_Err <= 1'b0;
    end else if (load_status) begin
      Stp_Err <= err_fold;
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  // Break flag: sticky until the next completed frame.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      Brk_Det <= 1'b0;
    end else if (load_status) begin
      Brk_Det <= Frame_All_Zero & zero_fold;
    end
  end
`endif

  // Saturating bad-frame counter; a clear wins over a same-cycle increment.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      Err_Cnt <= '0;
    end else if (Err_Cnt_Clr) begin
      Err_Cnt <= '0;
    end else if ((state_q == DONE) && Stp_Err && (Err_Cnt != '1)) begin
      Err_Cnt <= Err_Cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_rx_stop_checker.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_stop_checker
//   Directed bench for uart_rx_stop_checker. Two instances share all inputs:
//   u_dut uses the default 8-bit error counter, and u_sat uses a 2-bit counter
//   to exercise saturation. Honours UART_RX_BREAK_DET_EN when defined.
// -----------------------------------------------------------------------------
module tb_uart_rx_stop_checker;

  logic       CLK;
  logic       RST;
  logic       Stp_Chk_En;
  logic       Sampled_Bit;
  logic [7:0] Prescale;
  logic [7:0] Edge_Cnt;
  logic [1:0] Stop_Bits;
  logic       Err_Cnt_Clr;
  logic       Stp_Busy, Stp_Done, Stp_Err;
  logic [7:0] Err_Cnt;
  logic       sat_busy, sat_done, sat_err;
  logic [1:0] sat_cnt;
`ifdef UART_RX_BREAK_DET_EN
  logic       Frame_All_Zero;
  logic       Brk_Det;
  logic       sat_brk;
`endif

  int checks   = 0;
  int failures = 0;

  uart_rx_stop_checker #(.PRESCALE_W(8), .MAX_STOP(2), .SAMPLE_OFFSET(2), .ERR_CNT_W(8)) u_dut (
    .CLK(CLK), .RST(RST), .Stp_Chk_En(Stp_Chk_En), .Sampled_Bit(Sampled_Bit),
    .Prescale(Prescale), .Edge_Cnt(Edge_Cnt), .Stop_Bits(Stop_Bits), .Err_Cnt_Clr(Err_Cnt_Clr),
`ifdef UART_RX_BREAK_DET_EN
    .Frame_All_Zero(Frame_All_Zero), .Brk_Det(Brk_Det),
`endif
    .Stp_Busy(Stp_Busy), .Stp_Done(Stp_Done), .Stp_Err(Stp_Err), .Err_Cnt(Err_Cnt)
  );

  uart_rx_stop_checker #(.PRESCALE_W(8), .MAX_STOP(2), .SAMPLE_OFFSET(2), .ERR_CNT_W(2)) u_sat (
    .CLK(CLK), .RST(RST), .Stp_Chk_En(Stp_Chk_En), .Sampled_Bit(Sampled_Bit),
    .Prescale(Prescale), .Edge_Cnt(Edge_Cnt), .Stop_Bits(Stop_Bits), .Err_Cnt_Clr(Err_Cnt_Clr),
`ifdef UART_RX_BREAK_DET_EN
    .Frame_All_Zero(Frame_All_Zero), .Brk_Det(sat_brk),
`endif
    .Stp_Busy(sat_busy), .Stp_Done(sat_done), .Stp_Err(sat_err), .Err_Cnt(sat_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("check %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One complete frame: stop bits are driven edge by edge, and the line is held
  // at 1 except at sample point sp, where it takes lines[bit]. Then the DONE
  // cycle, the no-retrigger cycle and the release are checked.
  task automatic run_frame(input string tag, input int p, input logic [1:0] sb, input int nbits,
                           input int sp, input logic [2:0] lines, input logic clr,
                           input logic exp_err, input logic exp_brk,
                           input logic [7:0] exp_cnt8, input logic [1:0] exp_cnt2);
    Prescale    = p[7:0];
    Stop_Bits   = sb;
    Stp_Chk_En  = 1'b1;
    Edge_Cnt    = 8'd0;
    Sampled_Bit = 1'b1;
    tick();
    check({tag, "_busy"}, Stp_Busy, 1'b1);
    for (int b = 0; b < nbits; b++) begin
      for (int e = 0; e < p; e++) begin
        Edge_Cnt    = e[7:0];
        Sampled_Bit = (e == sp) ? lines[b] : 1'b1;
        tick();
      end
    end
    Sampled_Bit = 1'b1;
    check({tag, "_done"}, Stp_Done, 1'b1);
    check({tag, "_err"}, Stp_Err, exp_err);
`ifdef UART_RX_BREAK_DET_EN
    check({tag, "_brk"}, Brk_Det, exp_brk);
`else
    if (exp_brk) $display("note: %s break expectation ignored in this build", tag);
`endif
    Err_Cnt_Clr = clr;
    tick();
    Err_Cnt_Clr = 1'b0;
    check({tag, "_done_low"}, Stp_Done, 1'b0);
    check({tag, "_cnt8"}, Err_Cnt, exp_cnt8);
    check({tag, "_cnt2"}, sat_cnt, exp_cnt2);
    tick();
    check({tag, "_no_retrig"}, Stp_Busy, 1'b0);
    check({tag, "_err_hold"}, Stp_Err, exp_err);
    Stp_Chk_En = 1'b0;
    tick();
  endtask

  initial begin
    RST         = 1'b0;
    Stp_Chk_En  = 1'b0;
    Sampled_Bit = 1'b1;
    Prescale    = 8'd8;
    Edge_Cnt    = 8'd0;
    Stop_Bits   = 2'd1;
    Err_Cnt_Clr = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    Frame_All_Zero = 1'b0;
`endif

    // Reset state.
    tick();
    tick();
    check("rst_busy", Stp_Busy, 1'b0);
    check("rst_done", Stp_Done, 1'b0);
    check("rst_err", Stp_Err, 1'b0);
    check("rst_cnt8", Err_Cnt, 8'd0);
    check("rst_cnt2", sat_cnt, 2'd0);
`ifdef UART_RX_BREAK_DET_EN
    check("rst_brk", Brk_Det, 1'b0);
`endif
    RST = 1'b1;
    tick();

    // P=8, N=1, good stop bit: SP=6, EP=7.
    run_frame("good8", 8, 2'd1, 1, 6, 3'b001, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    // P=16, N=2, second stop bit 0 at SP=10.
    run_frame("bad16", 16, 2'd2, 2, 10, 3'b001, 1'b0, 1'b1, 1'b0, 8'd1, 2'd1);
    // P=4: SP=(2+2) clamps to EP=3; Stop_Bits=0 acts as 1.
    run_frame("clamp4", 4, 2'd0, 1, 3, 3'b000, 1'b0, 1'b1, 1'b0, 8'd2, 2'd2);
    // Good frame so the abort below has Stp_Err=0 to hold.
    run_frame("good8b", 8, 2'd1, 1, 6, 3'b001, 1'b0, 1'b0, 1'b0, 8'd2, 2'd2);

    // Abort during the first of two stop bits, after a 0 sample at SP=6.
    Prescale   = 8'd8;
    Stop_Bits  = 2'd2;
    Stp_Chk_En = 1'b1;
    Edge_Cnt   = 8'd0;
    tick();
    check("abort_busy", Stp_Busy, 1'b1);
    for (int e = 0; e < 7; e++) begin
      Edge_Cnt    = e[7:0];
      Sampled_Bit = (e == 6) ? 1'b0 : 1'b1;
      tick();
    end
    Sampled_Bit = 1'b1;
    Stp_Chk_En  = 1'b0;
    Edge_Cnt    = 8'd7;
    tick();
    check("abort_idle", Stp_Busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("abort_no_done", Stp_Done, 1'b0);
      tick();
    end
    check("abort_err_hold", Stp_Err, 1'b0);
    check("abort_cnt8", Err_Cnt, 8'd2);
    check("abort_cnt2", sat_cnt, 2'd2);

    // Stop_Bits=3 clamps to MAX_STOP=2.
    run_frame("clamp_n", 8, 2'd3, 2, 6, 3'b011, 1'b0, 1'b0, 1'b0, 8'd2, 2'd2);
    // Bad frame with clear in the DONE cycle: clear wins.
    run_frame("clr0", 4, 2'd1, 1, 3, 3'b000, 1'b1, 1'b1, 1'b0, 8'd0, 2'd0);
    // Saturation of the 2-bit counter: 1,2,3,3.
    run_frame("sat1", 4, 2'd1, 1, 3, 3'b000, 1'b0, 1'b1, 1'b0, 8'd1, 2'd1);
    run_frame("sat2", 4, 2'd1, 1, 3, 3'b000, 1'b0, 1'b1, 1'b0, 8'd2, 2'd2);
    run_frame("sat3", 4, 2'd1, 1, 3, 3'b000, 1'b0, 1'b1, 1'b0, 8'd3, 2'd3);
    run_frame("sat4", 4, 2'd1, 1, 3, 3'b000, 1'b0, 1'b1, 1'b0, 8'd4, 2'd3);
    // Fifth bad frame with clear in the same cycle.
    run_frame("sat_clr", 4, 2'd1, 1, 3, 3'b000, 1'b1, 1'b1, 1'b0, 8'd0, 2'd0);

`ifdef UART_RX_BREAK_DET_EN
    // Break frame: all-zero data and stop sampled 0.
    Frame_All_Zero = 1'b1;
    run_frame("brk", 8, 2'd1, 1, 6, 3'b000, 1'b0, 1'b1, 1'b1, 8'd1, 2'd1);
    check("brk_sticky", Brk_Det, 1'b1);
    // Next good frame clears it.
    run_frame("brk_clr", 8, 2'd1, 1, 6, 3'b001, 1'b0, 1'b0, 1'b0, 8'd1, 2'd1);
    // One of two stop samples 0: not a break.
    run_frame("brk_part", 8, 2'd2, 2, 6, 3'b010, 1'b0, 1'b1, 1'b0, 8'd2, 2'd2);
    Frame_All_Zero = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
